// File: rtl/fetch_decode_unit_pkg.sv
// Shared encodings for the fetch/decode unit, the PC stage and the ALU stage.
// Contents:
//   opcode_e     - instruction opcodes in instr[15:12] (0001..0111 are ALU ops)
//   jump_sel_e   - PC next-value select codes driven towards the PC stage
//   state_e      - fetch/decode FSM state encoding
//   is_alu_op()  - true for the ALU opcode range
package fetch_decode_unit_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_JMP  = 4'h8,
    OP_BR1  = 4'h9,
    OP_BR2  = 4'ha,
    OP_BR3  = 4'hb,
    OP_BR4  = 4'hc,
    OP_BR5  = 4'hd,
    OP_RST  = 4'he,
    OP_HALT = 4'hf
  } opcode_e;

  typedef enum logic [2:0] {
    JS_RESET = 3'b000,
    JS_JUMP  = 3'b001,
    JS_BR1   = 3'b010,
    JS_BR2   = 3'b011,
    JS_BR3   = 3'b100,
    JS_BR4   = 3'b101,
    JS_BR5   = 3'b110,
    JS_INCR  = 3'b111
  } jump_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd7);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   instr       in  16  instruction word (from the instruction register)
//   opcode      out 4   instr[15:12]
//   jump_select out 3   PC next-value select for this opcode
//   alu_flag    out 1   opcode is an ALU operation
//   halt_flag   out 1   opcode is HALT
//   immediate   out 10  instr[9:0] (signed offset)
//   rd, rs, rt  out 3   register fields instr[11:9], instr[8:6], instr[5:3]
module instr_decoder
  import fetch_decode_unit_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [2:0]  jump_select,
  output logic        alu_flag,
  output logic        halt_flag,
  output logic [9:0]  immediate,
  output logic [2:0]  rd,
  output logic [2:0]  rs,
  output logic [2:0]  rt
);

  // Field extraction and opcode classification
  always_comb begin
    opcode      = instr[15:12];
    immediate   = instr[9:0];
    rd          = instr[11:9];
    rs          = instr[8:6];
    rt          = instr[5:3];
    alu_flag    = is_alu_op(instr[15:12]);
    halt_flag   = (instr[15:12] == OP_HALT);
    jump_select = JS_INCR;
    // HALT never advances the PC, so its select value is left at increment.
    case (instr[15:12])
      OP_JMP:  jump_select = JS_JUMP;
      OP_BR1:  jump_select = JS_BR1;
      OP_BR2:  jump_select = JS_BR2;
      OP_BR3:  jump_select = JS_BR3;
      OP_BR4:  jump_select = JS_BR4;
      OP_BR5:  jump_select = JS_BR5;
      OP_RST:  jump_select = JS_RESET;
      default: jump_select = JS_INCR;
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode control unit: fetches one instruction per request, decodes it
// and issues a one-cycle PC advance (and ALU execute) strobe.
// Ports:
//   clock, reset  in      clock (rising edge), synchronous active-high reset
//   pc_value      in  10  current PC (signed, used as unsigned address)
//   instr_data    in  16  instruction word from memory
//   mem_ready     in  1   instr_data valid this cycle (honoured only in FETCH)
//   instr_req     out 1   fetch request
//   instr_addr    out 10  fetch address, pc_value captured on FETCH entry
//   pc_enable     out 1   PC advance strobe (EXECUTE)
//   jump_select   out 3   PC next-value select
//   immediate     out 10  signed branch offset
//   alu_en        out 1   ALU execute strobe (EXECUTE, ALU opcodes only)
//   alu_op        out 4   opcode
//   rd, rs, rt    out 3   register fields
//   halted        out 1   high while in HALT
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic signed [9:0] pc_value,
  input  logic [15:0]       instr_data,
  input  logic              mem_ready,
  output logic              instr_req,
  output logic [9:0]        instr_addr,
  output logic              pc_enable,
  output logic [2:0]        jump_select,
  output logic signed [9:0] immediate,
  output logic              alu_en,
  output logic [3:0]        alu_op,
  output logic [2:0]        rd,
  output logic [2:0]        rs,
  output logic [2:0]        rt,
  output logic              halted
);

  state_e              state_r, state_next_s;
  logic [15:0]         instr_reg_r;
  logic [3:0]          dec_opcode_s;
  logic [2:0]          dec_js_s;
  logic                dec_alu_s, dec_halt_s;
  logic [9:0]          dec_imm_s;
  logic [2:0]          dec_rd_s, dec_rs_s, dec_rt_s;
  logic                instr_req_r, pc_enable_r, alu_en_r, halted_r;
  logic [9:0]          instr_addr_r;
  logic [2:0]          jump_select_r;
  logic signed [9:0]   immediate_r;
  logic [3:0]          alu_op_r;
  logic [2:0]          rd_r, rs_r, rt_r;

  instr_decoder u_decoder (
    .instr       (instr_reg_r),
    .opcode      (dec_opcode_s),
    .jump_select (dec_js_s),
    .alu_flag    (dec_alu_s),
    .halt_flag   (dec_halt_s),
    .immediate   (dec_imm_s),
    .rd          (dec_rd_s),
    .rs          (dec_rs_s),
    .rt          (dec_rt_s)
  );

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:    state_next_s = ST_FETCH;
      ST_FETCH:   if (mem_ready) state_next_s = ST_DECODE; else state_next_s = ST_FETCH;
      ST_DECODE:  if (dec_halt_s) state_next_s = ST_HALT; else state_next_s = ST_EXECUTE;
      ST_EXECUTE: state_next_s = ST_FETCH;
      ST_HALT:    state_next_s = ST_HALT;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // State register and strobes; strobes are registered from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      instr_req_r <= 1'b0;
      pc_enable_r <= 1'b0;
      alu_en_r    <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      instr_req_r <= (state_next_s == ST_FETCH);
      pc_enable_r <= (state_next_s == ST_EXECUTE);
      alu_en_r    <= (state_next_s == ST_EXECUTE) && dec_alu_s;
      halted_r    <= (state_next_s == ST_HALT);
    end
  end

  // Fetch address capture on FETCH entry and instruction register load
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_addr_r <= 10'd0;
      instr_reg_r  <= 16'h0000;
    end else begin
      if ((state_r != ST_FETCH) && (state_next_s == ST_FETCH)) begin
        instr_addr_r <= $unsigned(pc_value);
      end
      if ((state_r == ST_FETCH) && mem_ready) begin
        instr_reg_r <= instr_data;
      end
    end
  end

  // Decoded fields, updated only in DECODE and held until the next DECODE
  always_ff @(posedge clock) begin
    if (reset) begin
      jump_select_r <= JS_INCR;
      immediate_r   <= 10'sd0;
      alu_op_r      <= 4'd0;
      rd_r          <= 3'd0;
      rs_r          <= 3'd0;
      rt_r          <= 3'd0;
    end else if (state_r == ST_DECODE) begin
      jump_select_r <= dec_js_s;
      immediate_r   <= $signed(dec_imm_s);
      alu_op_r      <= dec_opcode_s;
      rd_r          <= dec_rd_s;
      rs_r          <= dec_rs_s;
      rt_r          <= dec_rt_s;
    end
  end

  assign instr_req   = instr_req_r;
  assign instr_addr  = instr_addr_r;
  assign pc_enable   = pc_enable_r;
  assign alu_en      = alu_en_r;
  assign halted      = halted_r;
  assign jump_select = jump_select_r;
  assign immediate   = immediate_r;
  assign alu_op      = alu_op_r;
  assign rd          = rd_r;
  assign rs          = rs_r;
  assign rt          = rt_r;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: directed cases plus randomized
// instruction streams checked against a transaction-level reference model.
module tb_fetch_decode_unit;

  logic              clock = 1'b0;
  logic              reset;
  logic signed [9:0] pc_value;
  logic [15:0]       instr_data;
  logic              mem_ready;
  logic              instr_req;
  logic [9:0]        instr_addr;
  logic              pc_enable;
  logic [2:0]        jump_select;
  logic [9:0]        immediate;
  logic              alu_en;
  logic [3:0]        alu_op;
  logic [2:0]        rd, rs, rt;
  logic              halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: expected fetch address and held decode fields
  logic [9:0]  exp_addr;
  logic [2:0]  exp_js;
  logic [9:0]  exp_imm;
  logic [3:0]  exp_op;
  logic [2:0]  exp_rd, exp_rs, exp_rt;

  fetch_decode_unit dut (
    .clock       (clock),
    .reset       (reset),
    .pc_value    (pc_value),
    .instr_data  (instr_data),
    .mem_ready   (mem_ready),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .pc_enable   (pc_enable),
    .jump_select (jump_select),
    .immediate   (immediate),
    .alu_en      (alu_en),
    .alu_op      (alu_op),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .halted      (halted)
  );

  // Free-running clock
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // jump_select from the opcode table: ALU/NOP increment, JMP jump,
  // branches 9..13 map to 2..6, RST to reset-to-0
  function automatic logic [2:0] model_js(input int op);
    if (op <= 7)       return 3'd7;
    else if (op == 8)  return 3'd1;
    else if (op == 14) return 3'd0;
    else if (op == 15) return 3'd7;
    else               return 3'(op - 7);
  endfunction

  task automatic check_reset_state(input string tag);
    check_value({tag, "_req"},   32'(instr_req),   32'd0);
    check_value({tag, "_pce"},   32'(pc_enable),   32'd0);
    check_value({tag, "_alu"},   32'(alu_en),      32'd0);
    check_value({tag, "_halt"},  32'(halted),      32'd0);
    check_value({tag, "_js"},    32'(jump_select), 32'd7);
    check_value({tag, "_imm"},   32'(immediate),   32'd0);
    check_value({tag, "_op"},    32'(alu_op),      32'd0);
    check_value({tag, "_regs"},  32'({rd, rs, rt}), 32'd0);
    check_value({tag, "_addr"},  32'(instr_addr),  32'd0);
  endtask

  // Reset-model update of the held decode fields
  task automatic model_reset;
    exp_js = 3'd7; exp_imm = 10'd0; exp_op = 4'd0;
    exp_rd = 3'd0; exp_rs = 3'd0; exp_rt = 3'd0;
  endtask

  // From IDLE (sampled), present a PC and step into FETCH
  task automatic enter_fetch;
    pc_value = 10'($urandom);
    exp_addr = pc_value;
    tick;
    check_value("enter_fetch_req", 32'(instr_req), 32'd1);
  endtask

  // Called with the DUT in FETCH; leaves it in FETCH again (or in HALT)
  task automatic run_instr(input logic [15:0] instr, input int waits);
    int op;
    op = int'(instr[15:12]);
    for (int w = 0; w < waits; w++) begin
      mem_ready  = 1'b0;
      instr_data = 16'($urandom);
      pc_value   = 10'($urandom);
      check_value("wait_req",  32'(instr_req),   32'd1);
      check_value("wait_addr", 32'(instr_addr),  32'(exp_addr));
      check_value("wait_strb", 32'({pc_enable, alu_en}), 32'd0);
      check_value("wait_js",   32'(jump_select), 32'(exp_js));
      tick;
    end
    mem_ready  = 1'b1;
    instr_data = instr;
    pc_value   = 10'($urandom);
    check_value("fetch_req",  32'(instr_req),  32'd1);
    check_value("fetch_addr", 32'(instr_addr), 32'(exp_addr));
    tick;
    // DECODE: request dropped, old decode fields still held
    check_value("dec_req",  32'(instr_req),   32'd0);
    check_value("dec_strb", 32'({pc_enable, alu_en, halted}), 32'd0);
    check_value("dec_hold", 32'({jump_select, immediate, alu_op}), 32'({exp_js, exp_imm, exp_op}));
    mem_ready  = 1'($urandom);
    instr_data = 16'($urandom);
    tick;
    exp_js = model_js(op); exp_imm = instr[9:0]; exp_op = instr[15:12];
    exp_rd = instr[11:9];  exp_rs = instr[8:6];  exp_rt = instr[5:3];
    if (op == 15) begin
      check_value("halt_flag", 32'(halted),    32'd1);
      check_value("halt_pce",  32'(pc_enable), 32'd0);
      check_value("halt_req",  32'(instr_req), 32'd0);
    end else begin
      check_value("ex_pce",  32'(pc_enable),   32'd1);
      check_value("ex_alu",  32'(alu_en),      32'((op >= 1) && (op <= 7)));
      check_value("ex_req",  32'(instr_req),   32'd0);
      check_value("ex_js",   32'(jump_select), 32'(exp_js));
      check_value("ex_imm",  32'(immediate),   32'(exp_imm));
      check_value("ex_op",   32'(alu_op),      32'(exp_op));
      check_value("ex_regs", 32'({rd, rs, rt}), 32'({exp_rd, exp_rs, exp_rt}));
      pc_value = 10'($urandom);
      exp_addr = pc_value;
      tick;
      check_value("post_ex_strb", 32'({pc_enable, alu_en}), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; instr_data = 16'h0000; pc_value = 10'sd0;
    model_reset();
    repeat (3) tick;
    check_reset_state("reset");

    // ALU op 1: strobes in cycle 4 after release
    reset = 1'b0;
    enter_fetch();
    run_instr(16'h1250, 0);
    check_value("alu1_rd", 32'(exp_rd), 32'd1);
    // JMP with imm -2
    run_instr(16'h83FE, 0);
    // memory wait of 5 cycles
    run_instr(16'h3A5C, 5);
    // conditional branches and RST
    for (int op = 9; op <= 14; op++) begin
      logic [15:0] w;
      w = 16'($urandom);
      w[15:12] = 4'(op);
      run_instr(w, int'($urandom_range(0, 2)));
    end
    // randomized stream of non-halt instructions
    for (int i = 0; i < 60; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      w[15:12] = 4'($urandom_range(0, 14));
      run_instr(w, int'($urandom_range(0, 3)));
    end

    // reset during FETCH with data ready: nothing latched, back to IDLE
    reset = 1'b1; mem_ready = 1'b1; instr_data = 16'hF000;
    tick;
    check_reset_state("rst_fetch");
    model_reset();
    reset = 1'b0; mem_ready = 1'b0;
    enter_fetch();
    run_instr(16'h7123, 1);

    // HALT: sticky until reset
    run_instr(16'hF000, 0);
    for (int i = 0; i < 20; i++) begin
      mem_ready  = 1'($urandom);
      instr_data = 16'($urandom);
      pc_value   = 10'($urandom);
      tick;
      check_value("halt_hold", 32'({halted, instr_req, pc_enable, alu_en}), 32'b1000);
    end
    reset = 1'b1;
    tick;
    check_reset_state("halt_rst");
    reset = 1'b0;
    tick;
    check_value("after_halt_fetch", 32'(instr_req), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
